// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix add/subtract row engine: op encoding and FSM states.
package matrix_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/matrix_addsub_rows_if.sv
// Row-stream bus of the matrix add/subtract engine. The master drives the rows in and
// takes results out; the slave is the engine.
interface matrix_addsub_rows_if #(
  parameter int LANES = 5,
  parameter int EW    = 8
);
  logic                  start;
  logic                  op;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*EW-1:0]   m1_row;
  logic [LANES*EW-1:0]   m2_row;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*EW-1:0]   out_row;
  logic [LANES-1:0]      out_ovf;
  logic                  busy;
  logic                  done;
  logic                  ovf_sticky;

  modport master (
    output start, op, in_valid, m1_row, m2_row, out_ready,
    input  in_ready, out_valid, out_row, out_ovf, busy, done, ovf_sticky
  );

  modport slave (
    input  start, op, in_valid, m1_row, m2_row, out_ready,
    output in_ready, out_valid, out_row, out_ovf, busy, done, ovf_sticky
  );
endinterface

// File: rtl/addsub_lane.sv
// One signed add/subtract lane with overflow detect. Defining MATRIX_ADDSUB_SATURATE_EN
// clamps overflowing results; otherwise they wrap.
module addsub_lane
  import matrix_pkg::*;
#(
  parameter int EW = 8
) (
  input  logic [EW-1:0] i_a,
  input  logic [EW-1:0] i_b,
  input  logic          i_op,
  output logic [EW-1:0] o_res,
  output logic          o_ovf
);

  logic [EW:0] w_a;
  logic [EW:0] w_b;
  logic [EW:0] w_r;

  assign w_a   = {i_a[EW-1], i_a};
  assign w_b   = {i_b[EW-1], i_b};
  assign w_r   = (i_op == OP_ADD) ? (w_a + w_b) : (w_a - w_b);
  // The extra bit holds the true sign; disagreement with the EW-bit sign means overflow.
  assign o_ovf = w_r[EW] ^ w_r[EW-1];

`ifdef MATRIX_ADDSUB_SATURATE_EN
  assign o_res = !o_ovf   ? w_r[EW-1:0] :
                 w_r[EW]  ? {1'b1, {(EW-1){1'b0}}} :
                            {1'b0, {(EW-1){1'b1}}};
`else
  assign o_res = w_r[EW-1:0];
`endif

endmodule

// File: rtl/matrix_addsub_rows.sv
// Streaming matrix add/subtract engine: ROWS rows per operation, LANES signed lanes per row,
// registered output with per-lane and sticky overflow. Saturation via MATRIX_ADDSUB_SATURATE_EN.
module matrix_addsub_rows
  import matrix_pkg::*;
#(
  parameter int LANES = 5,
  parameter int EW    = 8,
  parameter int ROWS  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  matrix_addsub_rows_if.slave  bus
);

  localparam int CW = $clog2(ROWS + 1);

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_op;
  logic [CW-1:0]         r_in_cnt;
  logic [CW-1:0]         r_out_cnt;
  logic                  r_out_valid;
  logic [LANES*EW-1:0]   r_out_row;
  logic [LANES-1:0]      r_out_ovf;
  logic                  r_ovf_sticky;

  logic                  w_start_acc;
  logic                  w_in_ready;
  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_last_out;
  logic [LANES*EW-1:0]   w_res;
  logic [LANES-1:0]      w_ovf;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      addsub_lane #(.EW(EW)) u_lane (
        .i_a   (bus.m1_row[gi*EW +: EW]),
        .i_b   (bus.m2_row[gi*EW +: EW]),
        .i_op  (r_op),
        .o_res (w_res[gi*EW +: EW]),
        .o_ovf (w_ovf[gi])
      );
    end
  endgenerate

  assign w_start_acc = (r_state == IDLE) && bus.start;
  // A new row may enter only if the output register is empty or being drained this cycle.
  assign w_in_ready  = (r_state == RUN) && (r_in_cnt < CW'(ROWS)) &&
                       (!r_out_valid || bus.out_ready);
  assign w_in_fire   = bus.in_valid && w_in_ready;
  assign w_out_fire  = r_out_valid && bus.out_ready;
  assign w_last_out  = w_out_fire && (r_out_cnt == CW'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = RUN;
      RUN:     if (w_last_out) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op      <= OP_ADD;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else if (w_start_acc) begin
      r_op      <= bus.op;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_in_fire)  r_in_cnt  <= r_in_cnt + 1'b1;
      if (w_out_fire) r_out_cnt <= r_out_cnt + 1'b1;
    end
  end

  // A simultaneous input fire reloads the register, so valid stays high across the handoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_row   <= '0;
      r_out_ovf   <= '0;
    end else if (w_in_fire) begin
      r_out_valid <= 1'b1;
      r_out_row   <= w_res;
      r_out_ovf   <= w_ovf;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_start_acc) begin
      r_ovf_sticky <= 1'b0;
    end else if (w_out_fire) begin
      r_ovf_sticky <= r_ovf_sticky | (|r_out_ovf);
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_row    = r_out_row;
  assign bus.out_ovf    = r_out_ovf;
  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = (r_state == DONE);
  assign bus.ovf_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_matrix_addsub_rows.sv
// Directed, table-driven bench for matrix_addsub_rows (LANES=5, EW=8, ROWS=5); expected rows
// are hand-computed for both wrap and MATRIX_ADDSUB_SATURATE_EN builds.
module tb_matrix_addsub_rows;

  localparam int LANES = 5;
  localparam int EW    = 8;
  localparam int ROWS  = 5;
  localparam int W     = LANES * EW;
`ifdef MATRIX_ADDSUB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [W-1:0]     m1;
    logic [W-1:0]     m2;
    logic [W-1:0]     exp_wrap;
    logic [W-1:0]     exp_sat;
    logic [LANES-1:0] ovf;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  vec_t tbl [15];

  matrix_addsub_rows_if #(.LANES(LANES), .EW(EW)) bus ();

  matrix_addsub_rows #(.LANES(LANES), .EW(EW), .ROWS(ROWS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_row(input int i);
    return SAT ? tbl[i].exp_sat : tbl[i].exp_wrap;
  endfunction

  // Runs one ROWS-row operation from table entries base..base+ROWS-1.
  task automatic run_op(input string name, input int base, input logic opv, input int bp_at,
                        input bit poke_start, input logic exp_sticky);
    int in_idx = 0;
    int out_idx = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic exp_v = 1'b0;
    logic stall_prev = 1'b0;
    logic [W-1:0] held = '0;
    logic in_f, out_f, stall;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = opv;
    @(negedge clk);
    bus.start = 1'b0;
    chk({name, " busy after start"}, 64'(bus.busy), 64'd1);
    while (out_idx < ROWS && cyc < 60) begin
      bus.in_valid  = (in_idx < ROWS);
      bus.m1_row    = (in_idx < ROWS) ? tbl[base + in_idx].m1 : '0;
      bus.m2_row    = (in_idx < ROWS) ? tbl[base + in_idx].m2 : '0;
      bus.out_ready = !(bp_at >= 0 && cyc >= bp_at && cyc < bp_at + 3);
      bus.start     = poke_start && (cyc == 2);
      bus.op        = (poke_start && cyc == 2) ? ~opv : opv;
      #1;
      chk({name, " out_valid"}, 64'(bus.out_valid), 64'(exp_v));
      in_f  = bus.in_valid && bus.in_ready;
      out_f = bus.out_valid && bus.out_ready;
      stall = bus.out_valid && !bus.out_ready;
      if (stall) begin
        chk({name, " in_ready under stall"}, 64'(bus.in_ready), 64'd0);
        if (stall_prev) chk({name, " out_row stable"}, 64'(bus.out_row), 64'(held));
        held = bus.out_row;
      end
      stall_prev = stall;
      if (out_f) begin
        $display("%s row %0d: out_row=%h out_ovf=%b", name, out_idx, bus.out_row, bus.out_ovf);
        chk({name, " out_row"}, 64'(bus.out_row), 64'(exp_row(base + out_idx)));
        chk({name, " out_ovf"}, 64'(bus.out_ovf), 64'(tbl[base + out_idx].ovf));
        out_idx++;
      end
      exp_v = in_f ? 1'b1 : (out_f ? 1'b0 : exp_v);
      if (in_f) in_idx++;
      if (bus.done) done_cnt++;
      @(negedge clk);
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.start     = 1'b0;
    bus.op        = opv;
    if (out_idx < ROWS) chk({name, " rows out before timeout"}, 64'(out_idx), 64'(ROWS));
    chk({name, " done early"}, 64'(done_cnt), 64'd0);
    #1;
    chk({name, " done pulse"}, 64'(bus.done), 64'd1);
    chk({name, " busy in DONE"}, 64'(bus.busy), 64'd1);
    @(negedge clk);
    #1;
    chk({name, " done cleared"}, 64'(bus.done), 64'd0);
    chk({name, " busy cleared"}, 64'(bus.busy), 64'd0);
    chk({name, " ovf_sticky"}, 64'(bus.ovf_sticky), 64'(exp_sticky));
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    // Op A (add, no overflow): rows 0..4
    tbl[0]  = '{{8'h32,8'h01,8'h00,8'hFB,8'h0A}, {8'hC4,8'h01,8'h00,8'h03,8'h14},
                {8'hF6,8'h02,8'h00,8'hFE,8'h1E}, {8'hF6,8'h02,8'h00,8'hFE,8'h1E}, 5'b00000};
    tbl[1]  = '{{5{8'h01}}, {5{8'h02}}, {5{8'h03}}, {5{8'h03}}, 5'b00000};
    tbl[2]  = '{{5{8'h7E}}, {5{8'h01}}, {5{8'h7F}}, {5{8'h7F}}, 5'b00000};
    tbl[3]  = '{{5{8'h80}}, {5{8'h7F}}, {5{8'hFF}}, {5{8'hFF}}, 5'b00000};
    tbl[4]  = '{{5{8'hF0}}, {5{8'hF0}}, {5{8'hE0}}, {5{8'hE0}}, 5'b00000};
    // Op B (add, overflow): rows 5..9
    tbl[5]  = '{{8'h00,8'h00,8'h00,8'h00,8'h64}, {8'h00,8'h00,8'h00,8'h00,8'h32},
                {8'h00,8'h00,8'h00,8'h00,8'h96}, {8'h00,8'h00,8'h00,8'h00,8'h7F}, 5'b00001};
    tbl[6]  = '{{5{8'h80}}, {5{8'hFF}}, {5{8'h7F}}, {5{8'h80}}, 5'b11111};
    tbl[7]  = '{{8'h00,8'h00,8'h7F,8'h00,8'h00}, {8'h00,8'h00,8'h01,8'h00,8'h00},
                {8'h00,8'h00,8'h80,8'h00,8'h00}, {8'h00,8'h00,8'h7F,8'h00,8'h00}, 5'b00100};
    tbl[8]  = '{{5{8'h05}}, {5{8'h05}}, {5{8'h0A}}, {5{8'h0A}}, 5'b00000};
    tbl[9]  = '{{5{8'hFE}}, {5{8'h03}}, {5{8'h01}}, {5{8'h01}}, 5'b00000};
    // Op C (sub, overflow): rows 10..14
    tbl[10] = '{{8'h00,8'hFB,8'h1E,8'h7F,8'h80}, {8'h80,8'h03,8'h0A,8'hFF,8'h01},
                {8'h80,8'hF8,8'h14,8'h80,8'h7F}, {8'h7F,8'hF8,8'h14,8'h7F,8'h80}, 5'b10011};
    tbl[11] = '{{5{8'h10}}, {5{8'h20}}, {5{8'hF0}}, {5{8'hF0}}, 5'b00000};
    tbl[12] = '{{5{8'h81}}, {5{8'h01}}, {5{8'h80}}, {5{8'h80}}, 5'b00000};
    tbl[13] = '{{5{8'hFF}}, {5{8'hFF}}, {5{8'h00}}, {5{8'h00}}, 5'b00000};
    tbl[14] = '{{5{8'h7F}}, {5{8'h7F}}, {5{8'h00}}, {5{8'h00}}, 5'b00000};

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.op        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.m1_row    = '0;
    bus.m2_row    = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset in_ready",   64'(bus.in_ready),   64'd0);
    chk("reset out_valid",  64'(bus.out_valid),  64'd0);
    chk("reset out_row",    64'(bus.out_row),    64'd0);
    chk("reset out_ovf",    64'(bus.out_ovf),    64'd0);
    chk("reset busy",       64'(bus.busy),       64'd0);
    chk("reset done",       64'(bus.done),       64'd0);
    chk("reset ovf_sticky", 64'(bus.ovf_sticky), 64'd0);

    run_op("addA_bp", 0,  1'b0, 2,  1'b0, 1'b0);
    run_op("addB",    5,  1'b0, -1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk("sticky holds after DONE", 64'(bus.ovf_sticky), 64'd1);
    run_op("subC_poke", 10, 1'b1, -1, 1'b1, 1'b1);

    // Reset mid-run after two rows, with an overflowing row already emitted.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 1'b1;
      bus.m1_row   = tbl[5 + k].m1;
      bus.m2_row   = tbl[5 + k].m2;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #1;
    $display("midrun before reset: out_valid=%b ovf_sticky=%b", bus.out_valid, bus.ovf_sticky);
    chk("midrun sticky set",    64'(bus.ovf_sticky), 64'd1);
    chk("midrun out_valid set", 64'(bus.out_valid),  64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrun rst busy",       64'(bus.busy),       64'd0);
    chk("midrun rst out_valid",  64'(bus.out_valid),  64'd0);
    chk("midrun rst ovf_sticky", 64'(bus.ovf_sticky), 64'd0);
    chk("midrun rst done",       64'(bus.done),       64'd0);
    chk("midrun rst in_ready",   64'(bus.in_ready),   64'd0);
    @(negedge clk);
    #1;
    chk("midrun no late done",   64'(bus.done),       64'd0);

    run_op("addA_clean", 0, 1'b0, -1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_addsub_rows.md
# matrix_addsub_rows

Streaming matrix add/subtract engine for the coprocessor datapath. It takes a `ROWS`-row matrix pair one row per handshake and applies element-wise signed add or subtract across `LANES` lanes of `EW` bits. Results are registered and streamed out one row per handshake, with per-lane overflow flags and a per-operation sticky overflow. It replaces the fixed 5×8-bit combinational row subtractor in the ALU path.

## Interface
Parameters:
- `LANES`, default 5: elements per row.
- `EW`, default 8: element width, signed two's complement.
- `ROWS`, default 5: rows per matrix operation.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: begin operation. Sampled only in IDLE.
- `op`, in, 1: 0 = add (m1+m2), 1 = sub (m1−m2). Latched on accepted `start`.
- `in_valid`, in, 1: `m1_row`/`m2_row` valid.
- `in_ready`, out, 1: engine accepts a row this cycle.
- `m1_row`, in, LANES*EW: row of matrix 1. Lane i at bits [i*EW +: EW].
- `m2_row`, in, LANES*EW: row of matrix 2, same packing.
- `out_valid`, out, 1: `out_row` valid.
- `out_ready`, in, 1: downstream accepts the result.
- `out_row`, out, LANES*EW: result row, same packing.
- `out_ovf`, out, LANES: per-lane overflow for `out_row`.
- `busy`, out, 1: state ≠ IDLE.
- `done`, out, 1: one-cycle pulse at operation end.
- `ovf_sticky`, out, 1: OR of all `out_ovf` emitted in the current/last operation.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on `start`. Latches `op`, clears `in_cnt`, `out_cnt` and `ovf_sticky`.
- RUN → DONE when the output handshake for row `ROWS`−1 completes.
- DONE → IDLE unconditionally after one cycle. `done`=1 only in DONE.
- `start` outside IDLE is ignored. `ovf_sticky` holds after DONE until the next accepted `start` or `rst`.
- Input accept: `in_ready` = RUN && `in_cnt` < ROWS && (!`out_valid` || `out_ready`). Input fires on `in_valid` && `in_ready`, then `in_cnt`++.
- Output: `out_valid` sets on input fire. It clears on `out_valid` && `out_ready` with no simultaneous input fire. Simultaneous fire loads the new row, so `out_valid` stays 1.
- Per lane, both operands are sign-extended to EW+1 bits, then r = a ± b. Overflow = r[EW] ≠ r[EW−1]. Result is r[EW−1:0], or clamped per Configuration.
- `ovf_sticky` |= |`out_ovf` on each output handshake.
- Input rows arriving while not in RUN, or after `in_cnt` = ROWS, are not accepted (`in_ready`=0).
- `rst` mid-operation: all state discarded, return to IDLE, no `done`.
- Reset values: `in_ready`=0, `out_valid`=0, `out_row`=0, `out_ovf`=0, `busy`=0, `done`=0, `ovf_sticky`=0.

## Timing
- Latency: 1 cycle from input fire to `out_valid`.
- Throughput: 1 row/cycle when `out_ready` is held high.
- `out_row`/`out_ovf` hold stable while `out_valid` && !`out_ready`.
- Minimum operation: 1 cycle (start) + ROWS + 1 cycles (last output) + DONE cycle.
- `busy` rises the cycle after `start` and falls the cycle after DONE.

## Configuration
- `MATRIX_ADDSUB_SATURATE_EN` defined: an overflowing lane clamps to +(2^(EW−1)−1) if r[EW]=0, else −2^(EW−1). `out_ovf` is still reported.
- Not defined: an overflowing lane wraps (two's complement truncation). `out_ovf` is reported.

## Structure
- Shared package `matrix_pkg`: op encoding constants (`OP_ADD`=0, `OP_SUB`=1) and state enum (IDLE/RUN/DONE).
- Sub-module `addsub_lane` (parameter EW): combinational signed add/sub, overflow detect, optional saturation. Instantiated LANES times via generate.
- Top level holds the FSM, counters, output register and sticky flag.

## Test plan
- Add without overflow, EW=8: lane values 10+20, −5+3 → 30, −2. All `out_ovf`=0, `done` pulses after 5 rows.
- Add with overflow: 100+50 → wrap 0x96 (−106), or 127 with SAT_EN. `out_ovf` lane=1, `ovf_sticky`=1 after DONE.
- Sub with overflow: −128−1 → wrap 127, or −128 with SAT_EN. 127−(−1) → wrap −128, or 127 with SAT_EN.
- Backpressure: hold `out_ready`=0 for 3 cycles mid-stream → `in_ready`=0, `out_row` stable, no row lost or duplicated. Rows emerge in order.
- Reset mid-run after 2 rows → next cycle `busy`=0, `out_valid`=0, `ovf_sticky`=0, no `done`. New `start` runs a clean 5-row op.
- `start` pulsed during RUN → ignored; `op` unchanged, counts unaffected.
